conv_mem_loader: RTL
====================

CONV_MEM_LOADER -- requirements
Module: conv_mem_loader

Interface
REQ-001 The module SHALL have parameter COLUMN_LEN, default 13, meaning the number of 8-bit lanes per weight vector.
REQ-002 The module SHALL have parameter NUM_FILTERS, default 8, meaning the number of addresses per bank.
REQ-003 The module SHALL derive VECTOR_BW = 8*COLUMN_LEN, ADDR_BW = $clog2(NUM_FILTERS) and BANK_BW = 2 (banks 0-2 hold weights, bank 3 holds bias).
REQ-004 clk_i  input  1  single clock; all logic is on its rising edge.
REQ-005 rst_n_i  input  1  reset, synchronous and active-low.
REQ-006 start_i  input  1  begin a load sequence; sampled only in IDLE.
REQ-007 byte_i  input  8  parameter byte stream.
REQ-008 byte_valid_i  input  1  byte_i is valid.
REQ-009 byte_last_i  input  1  marks the final byte of the stream.
REQ-010 byte_ready_o  output  1  loader accepts byte_i this cycle.
REQ-011 wr_en_o  output  1  memory write strobe, connected to conv1d wr_en_i.
REQ-012 rd_en_o  output  1  tied to 0, connected to conv1d rd_en_i.
REQ-013 rd_wr_bank_o  output  BANK_BW  target bank.
REQ-014 rd_wr_addr_o  output  ADDR_BW  target address.
REQ-015 wr_data_o  output  VECTOR_BW  assembled write word.
REQ-016 busy_o  output  1  a load sequence is in progress.
REQ-017 done_o  output  1  one-cycle pulse when the sequence ends.
REQ-018 error_o  output  1  sticky framing-error flag, cleared by start_i or reset.

Function
REQ-019 The FSM SHALL have the states IDLE, COLLECT, WRITE and DONE.
REQ-020 IDLE with start_i=1 SHALL go to COLLECT, set bank=0, addr=0 and lane=0, and clear error_o; start_i SHALL be ignored in every other state.
REQ-021 A byte SHALL transfer only when byte_valid_i and byte_ready_o are both 1; byte_ready_o SHALL be 1 only in COLLECT.
REQ-022 Each accepted byte SHALL be placed in lane n of the word, bits [8n+7:8n], and the lane counter SHALL then increment (first byte goes to lane 0).
REQ-023 The word length SHALL be COLUMN_LEN bytes for banks 0-2 and 4 bytes for bank 3; bias occupies bits [31:0] and bits [VECTOR_BW-1:32] SHALL be written as 0.
REQ-024 The word register SHALL be cleared at the start of each word, so unfilled lanes are 0.
REQ-025 Accepting the final byte of a word SHALL move the FSM to WRITE on the next cycle.
REQ-026 WRITE SHALL last exactly one cycle, with wr_en_o=1 and bank, addr and data stable; wr_en_o SHALL be 0 in all other states.
REQ-027 After WRITE, addr SHALL increment; when addr wraps from NUM_FILTERS-1 to 0, bank SHALL increment.
REQ-028 The write order SHALL be bank 0 addr 0..NUM_FILTERS-1, then bank 1, bank 2, bank 3.
REQ-029 The total stream length SHALL be 3*NUM_FILTERS*COLUMN_LEN + 4*NUM_FILTERS bytes (344 at the defaults).
REQ-030 A word of N bytes with valid held high SHALL occupy N+1 cycles (N collect cycles plus one write cycle).
REQ-031 The WRITE of bank 3, addr NUM_FILTERS-1 SHALL be followed by DONE, where done_o=1 for one cycle; the FSM SHALL then return to IDLE.
REQ-032 If byte_last_i=1 on an accepted byte that is not the final byte of the stream, the FSM SHALL set error_o and complete that word's WRITE (zero-padded), then go to DONE.
REQ-033 If the final byte of the stream is accepted with byte_last_i=0, the FSM SHALL set error_o and otherwise complete normally.
REQ-034 busy_o SHALL be 1 in COLLECT and WRITE and 0 in IDLE and DONE.
REQ-035 Gaps in byte_valid_i SHALL stall collection with no state change.
REQ-036 rd_wr_bank_o, rd_wr_addr_o and wr_data_o SHALL hold their last values outside WRITE.

Reset
REQ-037 rst_n_i=0 SHALL force the FSM to IDLE, set every counter and the word register to 0, and drive all outputs to 0.
REQ-038 A reset during COLLECT or WRITE SHALL abort the sequence without completing the pending write and without a done_o pulse.

Verification
REQ-039 Full load at defaults, bytes 0,1,2,... modulo 256, valid held high -> 32 writes; bank0/addr0 data lanes 0..12 = 0x00..0x0C; bank3/addr7 data = 0x...00_57565554 (bytes 340..343 = 0x54..0x57, upper 72 bits zero); done_o pulses once; error_o=0.
REQ-040 Random byte_valid_i gaps (50% duty) -> identical write sequence and data to the REQ-039 scenario, with wr_en_o never asserted while byte_ready_o=1.
REQ-041 byte_last_i asserted on byte 20 -> exactly two writes, the second being bank0/addr1 with lanes 0-7 = bytes 13..20 and lanes 8-12 = 0; error_o=1; done_o pulses.
REQ-042 Final byte 343 sent without byte_last_i -> all 32 writes occur, done_o pulses, error_o=1.
REQ-043 Reset asserted after byte 100 -> all outputs 0 on the next cycle; a new start_i then reloads from bank0/addr0.
REQ-044 start_i pulsed while busy_o=1 -> no effect on counters or the write sequence.

Source files
------------

// File: rtl/conv_mem_loader_if.sv
// Byte-stream and weight-memory bus of the conv1d parameter loader.
//   byte_i/byte_valid_i/byte_last_i : parameter byte stream into the loader
//   byte_ready_o                    : loader accepts byte_i this cycle
//   wr_en_o/rd_en_o                 : memory strobes towards conv1d
//   rd_wr_bank_o/rd_wr_addr_o       : target bank (0-2 weights, 3 bias) and address
//   wr_data_o                       : assembled write word
// The _i/_o suffixes are seen from the loader; the master modport is the loader side.
interface conv_mem_loader_if #(
    parameter int unsigned COLUMN_LEN  = 13,
    parameter int unsigned NUM_FILTERS = 8
) ();
    localparam int unsigned VECTOR_BW = 8 * COLUMN_LEN;
    localparam int unsigned ADDR_BW   = $clog2(NUM_FILTERS);
    localparam int unsigned BANK_BW   = 2;

    logic [7:0]           byte_i;
    logic                 byte_valid_i;
    logic                 byte_last_i;
    logic                 byte_ready_o;
    logic                 wr_en_o;
    logic                 rd_en_o;
    logic [BANK_BW-1:0]   rd_wr_bank_o;
    logic [ADDR_BW-1:0]   rd_wr_addr_o;
    logic [VECTOR_BW-1:0] wr_data_o;

    modport master (
        input  byte_i, byte_valid_i, byte_last_i,
        output byte_ready_o, wr_en_o, rd_en_o, rd_wr_bank_o, rd_wr_addr_o, wr_data_o
    );

    modport slave (
        output byte_i, byte_valid_i, byte_last_i,
        input  byte_ready_o, wr_en_o, rd_en_o, rd_wr_bank_o, rd_wr_addr_o, wr_data_o
    );
endinterface

// File: rtl/conv_mem_loader.sv
// Loads conv1d weights and biases from a byte stream into the banked weight memory.
// Bytes are packed little-endian into words (COLUMN_LEN bytes for weight banks 0-2,
// 4 bytes for bias bank 3) and written in order bank 0..3, addr 0..NUM_FILTERS-1.
//   clk_i    : clock, rising edge
//   rst_n_i  : synchronous active-low reset
//   start_i  : begin a load sequence (honoured only when idle)
//   bus      : byte stream in, memory write bus out (conv_mem_loader_if.master)
//   busy_o   : sequence in progress (collecting or writing)
//   done_o   : one-cycle pulse at the end of a sequence
//   error_o  : sticky framing error, cleared by start_i or reset
module conv_mem_loader #(
    parameter int unsigned COLUMN_LEN  = 13,
    parameter int unsigned NUM_FILTERS = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      start_i,
    conv_mem_loader_if.master         bus,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o
);
    localparam int unsigned VECTOR_BW = 8 * COLUMN_LEN;
    localparam int unsigned ADDR_BW   = $clog2(NUM_FILTERS);
    localparam int unsigned BANK_BW   = 2;
    localparam int unsigned LANE_BW   = $clog2(COLUMN_LEN);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCollect = 2'd1;
    localparam logic [1:0] StWrite   = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    localparam logic [BANK_BW-1:0] BiasBank     = 2'd3;
    localparam logic [ADDR_BW-1:0] LastAddr     = ADDR_BW'(NUM_FILTERS - 1);
    localparam logic [LANE_BW-1:0] LastLane     = LANE_BW'(COLUMN_LEN - 1);
    localparam logic [LANE_BW-1:0] BiasLastLane = LANE_BW'(3);

    logic [1:0]           state_q, state_d;
    logic [BANK_BW-1:0]   bank_q, bank_d;
    logic [ADDR_BW-1:0]   addr_q, addr_d;
    logic [LANE_BW-1:0]   lane_q, lane_d;
    logic [VECTOR_BW-1:0] word_q, word_d;
    logic                 error_q, error_d;
    logic                 abort_q, abort_d;
    // Bus outputs are registered separately so they hold the last write while the
    // working counters and word register move on to the next word.
    logic [BANK_BW-1:0]   out_bank_q, out_bank_d;
    logic [ADDR_BW-1:0]   out_addr_q, out_addr_d;
    logic [VECTOR_BW-1:0] out_data_q, out_data_d;

    logic accept;
    logic word_end;
    logic stream_end;

    assign accept     = bus.byte_valid_i && (state_q == StCollect);
    assign word_end   = (bank_q == BiasBank) ? (lane_q == BiasLastLane) : (lane_q == LastLane);
    assign stream_end = word_end && (bank_q == BiasBank) && (addr_q == LastAddr);

    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        addr_d     = addr_q;
        lane_d     = lane_q;
        word_d     = word_q;
        error_d    = error_q;
        abort_d    = abort_q;
        out_bank_d = out_bank_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StCollect;
                    bank_d  = '0;
                    addr_d  = '0;
                    lane_d  = '0;
                    word_d  = '0;
                    error_d = 1'b0;
                    abort_d = 1'b0;
                end
            end
            StCollect: begin
                if (accept) begin
                    word_d[8*lane_q +: 8] = bus.byte_i;
                    if (bus.byte_last_i && !stream_end) begin
                        // Early end of stream: flush the zero-padded partial word.
                        error_d = 1'b1;
                        abort_d = 1'b1;
                        state_d = StWrite;
                    end else if (word_end) begin
                        if (stream_end && !bus.byte_last_i) begin
                            error_d = 1'b1;
                        end
                        state_d = StWrite;
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                    if (state_d == StWrite) begin
                        out_bank_d = bank_q;
                        out_addr_d = addr_q;
                        out_data_d = word_d;
                    end
                end
            end
            StWrite: begin
                lane_d = '0;
                word_d = '0;
                if (abort_q || ((bank_q == BiasBank) && (addr_q == LastAddr))) begin
                    state_d = StDone;
                end else begin
                    state_d = StCollect;
                    if (addr_q == LastAddr) begin
                        addr_d = '0;
                        bank_d = bank_q + 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            bank_q     <= '0;
            addr_q     <= '0;
            lane_q     <= '0;
            word_q     <= '0;
            error_q    <= 1'b0;
            abort_q    <= 1'b0;
            out_bank_q <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            addr_q     <= addr_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
            error_q    <= error_d;
            abort_q    <= abort_d;
            out_bank_q <= out_bank_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
        end
    end

    assign bus.byte_ready_o = (state_q == StCollect);
    assign bus.wr_en_o      = (state_q == StWrite);
    assign bus.rd_en_o      = 1'b0;
    assign bus.rd_wr_bank_o = out_bank_q;
    assign bus.rd_wr_addr_o = out_addr_q;
    assign bus.wr_data_o    = out_data_q;
    assign busy_o           = (state_q == StCollect) || (state_q == StWrite);
    assign done_o           = (state_q == StDone);
    assign error_o          = error_q;
endmodule
